// File: rtl/online_rule_min_max.sv
// Digit-serial fuzzy rule evaluation: per-rule online min of two MSB-first
// membership streams, online max across rules, registered 1-cycle output.
module online_rule_min_max #(
  parameter int BIT_COUNT = 8,
  parameter int NUM_RULES = 5,
  parameter int CNT_W     = (BIT_COUNT > 1) ? $clog2(BIT_COUNT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic [2*NUM_RULES-1:0] io_inBits,
  output logic                   io_outResultValid,
  output logic                   io_outResult,
  output logic                   io_done,
  output logic                   io_busy
);

  typedef enum logic {S_IDLE, S_RUN} fsm_t;
  typedef enum logic [1:0] {R_EQ, R_A_LT, R_B_LT} rule_t;

  localparam bit SINGLE_BIT = (BIT_COUNT == 1);

  fsm_t                 state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  rule_t                rule_q [NUM_RULES];
  rule_t                rule_d [NUM_RULES];
  rule_t                cur_st [NUM_RULES];
  logic [NUM_RULES-1:0] mask_q, mask_d, min_bits, cand;
  logic                 sample, last, res_bit;
  logic                 valid_q, result_q, done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rule_d   = rule_q;
    mask_d   = mask_q;
    min_bits = '0;
    cand     = '1;
    sample   = 1'b0;
    last     = 1'b0;
    res_bit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sample = io_start;
        last   = io_start && SINGLE_BIT;
        if (io_start && !SINGLE_BIT) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RUN: begin
        sample = 1'b1;
        cand   = mask_q;
        if (cnt_q == CNT_W'(BIT_COUNT - 1)) begin
          last    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // In IDLE the start cycle evaluates from fresh EQ states and a full mask.
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      cur_st[r] = (state_q == S_IDLE) ? R_EQ : rule_q[r];
      case (cur_st[r])
        R_EQ: begin
          min_bits[r] = io_inBits[2*r] & io_inBits[2*r+1];
          if (sample && (io_inBits[2*r] != io_inBits[2*r+1]))
            rule_d[r] = io_inBits[2*r] ? R_B_LT : R_A_LT;
          else if (sample)
            rule_d[r] = R_EQ;
        end
        R_A_LT: begin
          min_bits[r] = io_inBits[2*r];
          if (sample) rule_d[r] = R_A_LT;
        end
        R_B_LT: begin
          min_bits[r] = io_inBits[2*r+1];
          if (sample) rule_d[r] = R_B_LT;
        end
        default: min_bits[r] = 1'b0;
      endcase
    end

    res_bit = |(min_bits & cand);
    // Pruning only on a 1 result keeps at least one candidate alive.
    if (sample)
      mask_d = res_bit ? (cand & min_bits) : cand;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mask_q   <= '1;
      valid_q  <= 1'b0;
      result_q <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned r = 0; r < NUM_RULES; r++) rule_q[r] <= R_EQ;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      valid_q  <= sample;
      result_q <= sample & res_bit;
      done_q   <= last;
      for (int unsigned r = 0; r < NUM_RULES; r++) rule_q[r] <= rule_d[r];
    end
  end

  assign io_outResultValid = valid_q;
  assign io_outResult      = result_q;
  assign io_done           = done_q;
  assign io_busy           = (state_q == S_RUN);

endmodule
